// File: rtl/mips_ex_pkg.sv
// rtl/mips_ex_pkg.sv - shared encodings for the MIPS execute stage
//
// Purpose: AluOp classes, R-type funct codes, MULT/DIV state encoding and
// the default datapath width used by ex_mem_stage and ex_muldiv.
// Ports: none (package).
// Configuration: EX_DIV_EN enables the divider in the modules importing this.
package mips_ex_pkg;

  localparam int EX_W = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative signed MULT/DIV engine with HI/LO registers
//
// Purpose: runs one shift-add (mult) or restoring shift-subtract (div)
// iteration per enabled edge on operand magnitudes, then applies sign
// correction and writes HI/LO in the DONE state.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_hit            0 freezes every register of the engine
//   i_start_mul      begin a signed multiply (honoured only in IDLE)
//   i_start_div      begin a signed divide (only when EX_DIV_EN is defined)
//   i_a, i_b         rs / rt operands captured at start
//   o_busy           engine is not IDLE
//   o_hi, o_lo       HI / LO architectural registers
// Configuration: EX_DIV_EN builds the divider and the DIV state.
module ex_muldiv
  import mips_ex_pkg::*;
#(
  parameter int W         = EX_W,
  parameter int MD_CYCLES = EX_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_hit,
  input  logic         i_start_mul,
`ifdef EX_DIV_EN
  input  logic         i_start_div,
`endif
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

  md_state_t       r_state;
  md_state_t       w_state_nxt;
  logic [CW-1:0]   r_cnt;
  // Mult: {partial product, multiplier}. Div: {remainder, quotient}.
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_mag;      // multiplicand or divisor magnitude
  logic            r_neg_res;  // product / quotient needs negation
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;

  logic [W-1:0]    w_mag_a;
  logic [W-1:0]    w_mag_b;
  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_prod_fix;
  logic            w_start;

  assign w_mag_a = i_a[W-1] ? -i_a : i_a;
  assign w_mag_b = i_b[W-1] ? -i_b : i_b;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  assign w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_mag & {W{r_acc[0]}}};
  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;

`ifdef EX_DIV_EN
  logic            r_is_div;
  logic            r_neg_rem;  // remainder takes the dividend's sign
  logic            r_bzero;
  logic [W:0]      w_shift;
  logic            w_ge;
  logic [W-1:0]    w_diff;
  logic [2*W-1:0]  w_div_nxt;

  assign w_start = i_start_mul | i_start_div;

  // Restoring step: shift the next dividend bit into the remainder; the
  // true difference is below the divisor, so W bits hold it exactly.
  assign w_shift   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_ge      = (w_shift >= {1'b0, r_mag});
  assign w_diff    = w_shift[W-1:0] - r_mag;
  assign w_div_nxt = w_ge ? {w_diff, r_acc[W-2:0], 1'b1}
                          : {w_shift[W-1:0], r_acc[W-2:0], 1'b0};
`else
  assign w_start = i_start_mul;
`endif

  assign o_busy = (r_state != MD_IDLE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: begin
        if (i_start_mul) begin
          w_state_nxt = MD_MUL;
        end
`ifdef EX_DIV_EN
        else if (i_start_div) begin
          w_state_nxt = MD_DIV;
        end
`endif
      end
      MD_MUL: begin
        if (r_cnt == LAST) w_state_nxt = MD_DONE;
      end
`ifdef EX_DIV_EN
      MD_DIV: begin
        if (r_cnt == LAST) w_state_nxt = MD_DONE;
      end
`endif
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= MD_IDLE;
    end else if (i_hit) begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mag     <= '0;
      r_neg_res <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef EX_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_bzero   <= 1'b0;
`endif
    end else if (i_hit) begin
      case (r_state)
        MD_IDLE: begin
          if (w_start) begin
            r_cnt     <= '0;
            r_neg_res <= i_a[W-1] ^ i_b[W-1];
            r_acc     <= {{W{1'b0}}, w_mag_b};
            r_mag     <= w_mag_a;
`ifdef EX_DIV_EN
            r_is_div  <= ~i_start_mul;
            r_neg_rem <= i_a[W-1];
            r_bzero   <= (i_b == '0);
            if (!i_start_mul) begin
              r_acc <= {{W{1'b0}}, w_mag_a};
              r_mag <= w_mag_b;
            end
`endif
          end
        end
        MD_MUL: begin
          r_acc <= {w_sum, r_acc[W-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
`ifdef EX_DIV_EN
        MD_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
`endif
        MD_DONE: begin
`ifdef EX_DIV_EN
          if (r_is_div) begin
            r_hi <= r_neg_rem ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
            // Division by zero leaves the quotient all ones regardless of sign.
            if (r_bzero) r_lo <= '1;
            else         r_lo <= r_neg_res ? -r_acc[W-1:0] : r_acc[W-1:0];
          end else
`endif
          begin
            r_hi <= w_prod_fix[2*W-1:W];
            r_lo <= w_prod_fix[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - MIPS execute stage with EX/MEM pipeline register
//
// Purpose: ALU operand select and operation decode, branch target adder,
// EX/MEM register, and the MULT/DIV engine that stalls upstream via busy.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   hit                   0 freezes the whole stage
//   PC                    PC+4 of the instruction in EX
//   readData1, readData2  register operands
//   immediate             sign-extended immediate, [5:0] = funct
//   rt, rd                destination candidates
//   RegDst..Branch, AluOp control from ID/EX
//   busy                  MULT/DIV running, upstream holds its inputs
//   *Out                  registered EX/MEM outputs
// Configuration: EX_DIV_EN enables funct 0x1A (signed divide).
module ex_mem_stage
  import mips_ex_pkg::*;
#(
  parameter int W         = EX_W,
  parameter int MD_CYCLES = EX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hit,
  input  logic [W-1:0] PC,
  input  logic [W-1:0] readData1,
  input  logic [W-1:0] readData2,
  input  logic [W-1:0] immediate,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  input  logic         RegDst,
  input  logic         AluSrc,
  input  logic         MemtoReg,
  input  logic         RegWrite,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         Branch,
  input  logic [1:0]   AluOp,
  output logic         busy,
  output logic [W-1:0] aluResultOut,
  output logic [W-1:0] writeDataOut,
  output logic [W-1:0] branchTargetOut,
  output logic         zeroOut,
  output logic [4:0]   writeRegOut,
  output logic         MemtoRegOut,
  output logic         RegWriteOut,
  output logic         MemReadOut,
  output logic         MemWriteOut,
  output logic         BranchOut
);

  logic [W-1:0] w_opb;
  logic [5:0]   w_funct;
  logic [W-1:0] w_result;
  logic         w_wr_en;
  logic         w_start_mul;
  logic         w_start_div;
  logic         w_bubble;
  logic         w_busy;
  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo;

  logic [W-1:0] r_alu_result;
  logic [W-1:0] r_write_data;
  logic [W-1:0] r_branch_target;
  logic         r_zero;
  logic [4:0]   r_write_reg;
  logic         r_memtoreg;
  logic         r_regwrite;
  logic         r_memread;
  logic         r_memwrite;
  logic         r_branch;

  assign w_opb   = AluSrc ? immediate : readData2;
  assign w_funct = immediate[5:0];

  always_comb begin
    w_result    = '0;
    w_wr_en     = 1'b1;
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    case (AluOp)
      ALUOP_ADD: w_result = readData1 + w_opb;
      ALUOP_SUB: w_result = readData1 - w_opb;
      ALUOP_OR:  w_result = readData1 | w_opb;
      default: begin
        case (w_funct)
          FUNCT_ADD:  w_result = readData1 + w_opb;
          FUNCT_SUB:  w_result = readData1 - w_opb;
          FUNCT_AND:  w_result = readData1 & w_opb;
          FUNCT_OR:   w_result = readData1 | w_opb;
          FUNCT_SLT:  w_result = {{(W-1){1'b0}}, $signed(readData1) < $signed(w_opb)};
          FUNCT_MFHI: w_result = w_hi;
          FUNCT_MFLO: w_result = w_lo;
          // The held instruction is still presented while busy; only the
          // first presentation in IDLE may start the engine.
          FUNCT_MULT: w_start_mul = ~w_busy;
`ifdef EX_DIV_EN
          FUNCT_DIV:  w_start_div = ~w_busy;
`endif
          default:    w_wr_en = 1'b0;
        endcase
      end
    endcase
  end

  // The issuing edge and every busy edge retire a bubble downstream.
  assign w_bubble = w_busy | w_start_mul | w_start_div;

  ex_muldiv #(
    .W         (W),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hit       (hit),
    .i_start_mul (w_start_mul),
`ifdef EX_DIV_EN
    .i_start_div (w_start_div),
`endif
    .i_a         (readData1),
    .i_b         (readData2),
    .o_busy      (w_busy),
    .o_hi        (w_hi),
    .o_lo        (w_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_result    <= '0;
      r_write_data    <= '0;
      r_branch_target <= '0;
      r_zero          <= 1'b0;
      r_write_reg     <= '0;
      r_memtoreg      <= 1'b0;
      r_regwrite      <= 1'b0;
      r_memread       <= 1'b0;
      r_memwrite      <= 1'b0;
      r_branch        <= 1'b0;
    end else if (hit) begin
      r_alu_result    <= w_result;
      r_write_data    <= readData2;
      r_branch_target <= PC + (immediate << 2);
      r_zero          <= (w_result == '0);
      r_write_reg     <= RegDst ? rd : rt;
      r_memtoreg      <= MemtoReg;
      r_regwrite      <= RegWrite & w_wr_en & ~w_bubble;
      r_memread       <= MemRead & ~w_bubble;
      r_memwrite      <= MemWrite & ~w_bubble;
      r_branch        <= Branch & ~w_bubble;
    end
  end

  assign busy            = w_busy;
  assign aluResultOut    = r_alu_result;
  assign writeDataOut    = r_write_data;
  assign branchTargetOut = r_branch_target;
  assign zeroOut         = r_zero;
  assign writeRegOut     = r_write_reg;
  assign MemtoRegOut     = r_memtoreg;
  assign RegWriteOut     = r_regwrite;
  assign MemReadOut      = r_memread;
  assign MemWriteOut     = r_memwrite;
  assign BranchOut       = r_branch;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hit = 1'b1;
  logic [31:0] PC = '0, readData1 = '0, readData2 = '0, immediate = '0;
  logic [4:0]  rt = '0, rd = '0;
  logic        RegDst = 1'b0, AluSrc = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, Branch = 1'b0;
  logic [1:0]  AluOp = '0;
  logic        busy;
  logic [31:0] aluResultOut, writeDataOut, branchTargetOut;
  logic        zeroOut;
  logic [4:0]  writeRegOut;
  logic        MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .PC(PC),
    .readData1(readData1), .readData2(readData2), .immediate(immediate),
    .rt(rt), .rd(rd), .RegDst(RegDst), .AluSrc(AluSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .AluOp(AluOp), .busy(busy), .aluResultOut(aluResultOut),
    .writeDataOut(writeDataOut), .branchTargetOut(branchTargetOut),
    .zeroOut(zeroOut), .writeRegOut(writeRegOut), .MemtoRegOut(MemtoRegOut),
    .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut),
    .MemWriteOut(MemWriteOut), .BranchOut(BranchOut)
  );

  always #5 clk = ~clk;

  // ctl = {MemtoReg, RegWrite, MemRead, MemWrite, Branch}
  typedef struct {
    logic [1:0]  aluop;
    logic [31:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic        alusrc;
    logic        regdst;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [4:0]  ctl;
    logic [31:0] e_res;
    logic        e_zero;
    logic [4:0]  e_wreg;
    logic        e_rw;
    logic [31:0] e_bt;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [4:0]  wreg;
    logic        rw;
    logic [3:0]  ctl;
    logic [31:0] bt;
    logic [31:0] wd;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[15];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    AluOp = v.aluop; immediate = v.imm; readData1 = v.a; readData2 = v.b;
    AluSrc = v.alusrc; RegDst = v.regdst; rt = v.rt; rd = v.rd; PC = v.pc;
    {MemtoReg, RegWrite, MemRead, MemWrite, Branch} = v.ctl;
  endtask

  function automatic vec_t mk_r(input logic [5:0] f, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rdv,
                                input logic [31:0] e_res, input logic e_rw);
    vec_t v;
    v.aluop = 2'b10; v.imm = {26'b0, f}; v.a = a; v.b = b; v.alusrc = 1'b0;
    v.regdst = 1'b1; v.rt = 5'd0; v.rd = rdv; v.pc = 32'h0; v.ctl = 5'b01000;
    v.e_res = e_res; v.e_zero = (e_res == 32'h0); v.e_wreg = rdv; v.e_rw = e_rw;
    v.e_bt = {24'b0, f, 2'b00};
    return v;
  endfunction

  // Drive one instruction, queue its expected EX/MEM image, compare after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    drive(v);
    e.res = v.e_res; e.zero = v.e_zero; e.wreg = v.e_wreg; e.rw = v.e_rw;
    e.ctl = {v.ctl[4], v.ctl[2], v.ctl[1], v.ctl[0]}; e.bt = v.e_bt; e.wd = v.b;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({tag, "_result"}, aluResultOut, e.res);
    chk({tag, "_zero"}, 32'(zeroOut), 32'(e.zero));
    chk({tag, "_wreg"}, 32'(writeRegOut), 32'(e.wreg));
    chk({tag, "_regwrite"}, 32'(RegWriteOut), 32'(e.rw));
    chk({tag, "_ctl"}, 32'({MemtoRegOut, MemReadOut, MemWriteOut, BranchOut}), 32'(e.ctl));
    chk({tag, "_target"}, branchTargetOut, e.bt);
    chk({tag, "_wdata"}, writeDataOut, e.wd);
  endtask

  // Issue mult/div with all side-effect controls set, count busy cycles and
  // verify bubbles; optionally drop hit for 'hold' cycles mid-operation.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    vec_t v;
    int   n;
    logic bad;
    v = mk_r(f, a, b, 5'd5, 32'h0, 1'b0);
    v.ctl = 5'b01111;
    drive(v);
    @(posedge clk);
    @(negedge clk);
    n = 0;
    bad = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if ({RegWriteOut, MemReadOut, MemWriteOut, BranchOut} !== 4'b0000) bad = 1'b1;
      if (hold > 0 && n == 10) hit = 1'b0;
      if (hold > 0 && n == 10 + hold) hit = 1'b1;
      @(negedge clk);
    end
    hit = 1'b1;
    chk({tag, "_busy_cycles"}, 32'(n), 32'(33 + hold));
    chk({tag, "_bubble"}, 32'(bad), 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_result"}, aluResultOut, 32'h0);
    chk({tag, "_wdata"}, writeDataOut, 32'h0);
    chk({tag, "_target"}, branchTargetOut, 32'h0);
    chk({tag, "_wreg_zero_ctl"},
        32'({writeRegOut, zeroOut, MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut}),
        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{2'b10, 32'h20, 32'd5, 32'd7, 1'b0, 1'b1, 5'd9, 5'd3, 32'h0, 5'b01000, 32'd12, 1'b0, 5'd3, 1'b1, 32'h80};
    vecs[1]  = '{2'b01, 32'h0, 32'd9, 32'd9, 1'b0, 1'b0, 5'd4, 5'd3, 32'h40, 5'b01000, 32'd0, 1'b1, 5'd4, 1'b1, 32'h40};
    vecs[2]  = '{2'b01, 32'h4, 32'd3, 32'd3, 1'b0, 1'b0, 5'd0, 5'd0, 32'h100, 5'b00001, 32'd0, 1'b1, 5'd0, 1'b0, 32'h110};
    vecs[3]  = '{2'b00, 32'hFFFFFFFF, 32'd10, 32'h55, 1'b1, 1'b0, 5'd7, 5'd2, 32'h200, 5'b11100, 32'd9, 1'b0, 5'd7, 1'b1, 32'h1FC};
    vecs[4]  = '{2'b11, 32'h0000F0F0, 32'h0F00000F, 32'h0, 1'b1, 1'b0, 5'd8, 5'd0, 32'h0, 5'b01000, 32'h0F00F0FF, 1'b0, 5'd8, 1'b1, 32'h0003C3C0};
    vecs[5]  = '{2'b10, 32'h24, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1, 5'd0, 5'd10, 32'h0, 5'b01000, 32'h0F000F00, 1'b0, 5'd10, 1'b1, 32'h90};
    vecs[6]  = '{2'b10, 32'h25, 32'h1, 32'h2, 1'b0, 1'b1, 5'd0, 5'd11, 32'h0, 5'b01000, 32'h3, 1'b0, 5'd11, 1'b1, 32'h94};
    vecs[7]  = '{2'b10, 32'h22, 32'd3, 32'd5, 1'b0, 1'b1, 5'd0, 5'd12, 32'h0, 5'b01000, 32'hFFFFFFFE, 1'b0, 5'd12, 1'b1, 32'h88};
    vecs[8]  = '{2'b10, 32'h2A, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 5'd0, 5'd13, 32'h0, 5'b01000, 32'h1, 1'b0, 5'd13, 1'b1, 32'hA8};
    vecs[9]  = '{2'b10, 32'h2A, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd0, 5'd14, 32'h0, 5'b01000, 32'h0, 1'b1, 5'd14, 1'b1, 32'hA8};
    vecs[10] = '{2'b10, 32'h3F, 32'd5, 32'd6, 1'b0, 1'b1, 5'd0, 5'd15, 32'h0, 5'b01000, 32'h0, 1'b1, 5'd15, 1'b0, 32'hFC};
    vecs[11] = '{2'b10, 32'h20, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 5'd0, 5'd16, 32'h0, 5'b01000, 32'h80000000, 1'b0, 5'd16, 1'b1, 32'h80};
    vecs[12] = '{2'b10, 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 5'd17, 32'h0, 5'b01000, 32'h0, 1'b1, 5'd17, 1'b1, 32'h40};
    vecs[13] = '{2'b00, 32'h8, 32'h1000, 32'hDEAD, 1'b1, 1'b0, 5'd6, 5'd0, 32'h0, 5'b00010, 32'h1008, 1'b0, 5'd6, 1'b0, 32'h20};
    vecs[14] = '{2'b11, 32'h20, 32'hF0, 32'h0F, 1'b0, 1'b1, 5'd0, 5'd18, 32'h0, 5'b01000, 32'hFF, 1'b0, 5'd18, 1'b1, 32'h80};

    // Reset dominates even with a live instruction on the inputs.
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // -3 * 7 = -21
    run_md(6'h18, 32'hFFFFFFFD, 32'd7, 0, "mult");
    run_vec(mk_r(6'h12, 32'h0, 32'h0, 5'd20, 32'hFFFFFFEB, 1'b1), "mult_lo");
    run_vec(mk_r(6'h10, 32'h0, 32'h0, 5'd21, 32'hFFFFFFFF, 1'b1), "mult_hi");

`ifdef EX_DIV_EN
    run_md(6'h1A, 32'hFFFFFFF9, 32'd2, 0, "div");
    run_vec(mk_r(6'h12, 32'h0, 32'h0, 5'd20, 32'hFFFFFFFD, 1'b1), "div_lo");
    run_vec(mk_r(6'h10, 32'h0, 32'h0, 5'd21, 32'hFFFFFFFF, 1'b1), "div_hi");
    run_md(6'h1A, 32'd10, 32'd0, 0, "divz");
    run_vec(mk_r(6'h12, 32'h0, 32'h0, 5'd20, 32'hFFFFFFFF, 1'b1), "divz_lo");
    run_vec(mk_r(6'h10, 32'h0, 32'h0, 5'd21, 32'h0000000A, 1'b1), "divz_hi");
`else
    // Without the divider, div is an unsupported funct: no stall, no write.
    run_vec(mk_r(6'h1A, 32'd10, 32'd3, 5'd22, 32'h0, 1'b0), "nodiv");
    chk("nodiv_busy", 32'(busy), 32'h0);
    run_vec(mk_r(6'h12, 32'h0, 32'h0, 5'd20, 32'hFFFFFFEB, 1'b1), "nodiv_lo");
    run_vec(mk_r(6'h10, 32'h0, 32'h0, 5'd21, 32'hFFFFFFFF, 1'b1), "nodiv_hi");
`endif

    // -2^31 * -1 = +2^31 with a 5-cycle hit drop mid-operation.
    run_md(6'h18, 32'h80000000, 32'hFFFFFFFF, 5, "mult_hold");
    run_vec(mk_r(6'h12, 32'h0, 32'h0, 5'd20, 32'h80000000, 1'b1), "hold_lo");
    run_vec(mk_r(6'h10, 32'h0, 32'h0, 5'd21, 32'h0, 1'b1), "hold_hi");

    // Reset in the middle of a multiply.
    drive(mk_r(6'h18, 32'd6, 32'd7, 5'd5, 32'h0, 1'b0));
    @(posedge clk);
    repeat (5) @(negedge clk);
    chk("premid_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    drive(mk_r(6'h10, 32'h0, 32'h0, 5'd21, 32'h0, 1'b1));
    rst_n = 1'b1;
    run_vec(mk_r(6'h10, 32'h0, 32'h0, 5'd21, 32'h0, 1'b1), "rst_hi");
    run_vec(mk_r(6'h12, 32'h0, 32'h0, 5'd20, 32'h0, 1'b1), "rst_lo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
